// File: rtl/muldiv_unit_if.sv
// Start/busy/done handshake bundle between the EX stage and the iterative multiply/divide unit.
interface muldiv_unit_if #(
  parameter int unsigned n = 32
);
  logic         i_start;
  logic [2:0]   i_op;
  logic [n-1:0] i_a;
  logic [n-1:0] i_b;
  logic         i_flush;
  logic         o_busy;
  logic         o_done;
  logic [n-1:0] o_result;

  modport master (
    output i_start, i_op, i_a, i_b, i_flush,
    input  o_busy, o_done, o_result
  );

  modport slave (
    input  i_start, i_op, i_a, i_b, i_flush,
    output o_busy, o_done, o_result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide, one bit per cycle,
// on operand magnitudes with a single sign fix-up cycle before the result is published.
module muldiv_unit #(
  parameter int unsigned n = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);
  localparam int unsigned CW = $clog2(n);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [2:0]     r_op;
  logic           r_neg;
  logic [n-1:0]   r_mcand;
  logic [2*n-1:0] r_acc;
  logic           r_busy;
  logic           r_done;
  logic [n-1:0]   r_result;

  logic           w_sgn_a, w_sgn_b, w_a_neg, w_b_neg, w_b_zero, w_neg_start;
  logic [n-1:0]   w_a_mag, w_b_mag;
  logic [n:0]     w_sum, w_trial;
  logic [2*n-1:0] w_mul_next, w_div_next, w_prod;
  logic [n-1:0]   w_mul_res, w_div_raw, w_div_res, w_fix_res;

  // Operand signedness by funct3: MULH/MULHSU/DIV/REM treat A as signed, MULH/DIV/REM treat B as signed
  assign w_sgn_a  = (bus.i_op == 3'b001) || (bus.i_op == 3'b010) ||
                    (bus.i_op == 3'b100) || (bus.i_op == 3'b110);
  assign w_sgn_b  = (bus.i_op == 3'b001) || (bus.i_op == 3'b100) || (bus.i_op == 3'b110);
  assign w_a_neg  = w_sgn_a & bus.i_a[n-1];
  assign w_b_neg  = w_sgn_b & bus.i_b[n-1];
  assign w_b_zero = (bus.i_b == '0);
  assign w_a_mag  = w_a_neg ? -bus.i_a : bus.i_a;
  assign w_b_mag  = w_b_neg ? -bus.i_b : bus.i_b;

  // Remainder follows the dividend; a zero-divisor quotient stays all ones, so it is never negated
  assign w_neg_start = bus.i_op[2] ? (bus.i_op[1] ? w_a_neg : ((w_a_neg ^ w_b_neg) & ~w_b_zero))
                                   : (w_a_neg ^ w_b_neg);

  assign w_sum      = {1'b0, r_acc[2*n-1:n]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
  assign w_mul_next = {w_sum, r_acc[n-1:1]};

  // acc holds {rem, quot}; the trial subtraction uses the bit shifted out of rem as its MSB
  assign w_trial    = r_acc[2*n-1:n-1] - {1'b0, r_mcand};
  assign w_div_next = w_trial[n] ? {r_acc[2*n-2:0], 1'b0}
                                 : {w_trial[n-1:0], r_acc[n-2:0], 1'b1};

  assign w_prod     = r_neg ? -r_acc : r_acc;
  assign w_mul_res  = (r_op[1:0] == 2'b00) ? w_prod[n-1:0] : w_prod[2*n-1:n];
  assign w_div_raw  = r_op[1] ? r_acc[2*n-1:n] : r_acc[n-1:0];
  assign w_div_res  = r_neg ? -w_div_raw : w_div_raw;
  assign w_fix_res  = r_op[2] ? w_div_res : w_mul_res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (bus.i_flush) begin
            r_state <= S_IDLE;
          end else if (bus.i_start) begin
            r_state <= S_CALC;
            r_busy  <= 1'b1;
            r_op    <= bus.i_op;
            r_neg   <= w_neg_start;
            r_mcand <= bus.i_op[2] ? w_b_mag : w_a_mag;
            r_acc   <= {n'(0), (bus.i_op[2] ? w_a_mag : w_b_mag)};
            r_cnt   <= CW'(n - 1);
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          if (bus.i_flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_acc <= r_op[2] ? w_div_next : w_mul_next;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == '0) r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_busy <= 1'b0;
          if (bus.i_flush) begin
            r_state <= S_IDLE;
          end else begin
            r_result <= w_fix_res;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_busy   = r_busy;
  assign bus.o_done   = r_done;
  assign bus.o_result = r_result;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, handshake corner sequences,
// and random operations checked against a plain-arithmetic RV32M reference.
module tb_muldiv_unit;
  localparam int unsigned N   = 32;
  localparam int          LAT = N + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_unit_if #(.n(N)) bus ();
  muldiv_unit #(.n(N)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference RV32M semantics using 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb, q;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = sa / sb; return q[31:0];
      end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        q = sa % sb; return q[31:0];
      end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  // Presents a request for exactly one edge, then scrambles the inputs to prove capture
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.i_op    = op;
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_start = 1'b1;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    bus.i_op    = 3'($urandom);
    bus.i_a     = $urandom;
    bus.i_b     = $urandom;
  endtask

  task automatic wait_done(output int lat);
    int c;
    lat = 0;
    c   = 0;
    while (lat == 0 && c < 100) begin
      c++;
      @(posedge clk);
      #1;
      if (bus.o_done) lat = c;
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string name);
    int lat;
    start_op(op, a, b);
    check({name, "_busy"}, 32'(bus.o_busy), 32'd1);
    wait_done(lat);
    check({name, "_latency"}, 32'(lat), 32'(LAT));
    check(name, bus.o_result, exp);
    last_exp = exp;
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] sp [5];
    sp[0] = 32'h0; sp[1] = 32'h1; sp[2] = 32'hFFFF_FFFF; sp[3] = 32'h8000_0000; sp[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
    if ($urandom_range(0, 2) == 0) return 32'($urandom_range(0, 255));
    return $urandom;
  endfunction

  vec_t vecs [15];

  initial begin
    int lat;
    int dones;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3"};
    vecs[1]  = '{3'd1, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, "mulh_7_m3"};
    vecs[2]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, "mulh_min_min"};
    vecs[3]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max"};
    vecs[4]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1_max"};
    vecs[5]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, "div_m7_2"};
    vecs[6]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, "rem_m7_2"};
    vecs[7]  = '{3'd5, 32'd100,        32'd7,         32'd14,        "divu_100_7"};
    vecs[8]  = '{3'd7, 32'd100,        32'd7,         32'd2,         "remu_100_7"};
    vecs[9]  = '{3'd5, 32'h1234,       32'd0,         32'hFFFF_FFFF, "divu_by0"};
    vecs[10] = '{3'd6, 32'h1234,       32'd0,         32'h1234,      "rem_by0"};
    vecs[11] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "div_ovf"};
    vecs[12] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         "rem_ovf"};
    vecs[13] = '{3'd4, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF, "div_neg_by0"};
    vecs[14] = '{3'd6, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, "rem_neg_by0"};

    rst = 1'b1;
    bus.i_start = 1'b0; bus.i_flush = 1'b0; bus.i_op = '0; bus.i_a = '0; bus.i_b = '0;
    last_exp = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",   32'(bus.o_busy), 32'd0);
    check("rst_done",   32'(bus.o_done), 32'd0);
    check("rst_result", bus.o_result,    32'd0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);
      @(posedge clk);
      #1;
      check({vecs[i].name, "_done_pulse"}, 32'(bus.o_done), 32'd0);
    end

    // start while busy is ignored; start in the DONE cycle is accepted
    start_op(3'd0, 32'd3, 32'd5);
    repeat (4) @(posedge clk);
    #1;
    bus.i_op = 3'd4; bus.i_a = 32'd9; bus.i_b = 32'd3; bus.i_start = 1'b1;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    wait_done(lat);
    check("busy_start_latency", 32'(lat), 32'(LAT - 5));
    check("busy_start_result",  bus.o_result, 32'd15);
    run_op(3'd5, 32'd100, 32'd7, 32'd14, "done_cycle_start");
    @(posedge clk);
    #1;

    // flush mid-divide: no done, result untouched
    start_op(3'd4, 32'd1000, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    bus.i_flush = 1'b1;
    @(posedge clk);
    #1;
    bus.i_flush = 1'b0;
    check("flush_busy", 32'(bus.o_busy), 32'd0);
    dones = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.o_done) dones++;
    end
    check("flush_no_done", 32'(dones), 32'd0);
    check("flush_result",  bus.o_result, last_exp);

    // asynchronous reset mid-multiply
    start_op(3'd0, 32'd123, 32'd456);
    repeat (18) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_busy",   32'(bus.o_busy), 32'd0);
    check("arst_done",   32'(bus.o_done), 32'd0);
    check("arst_result", bus.o_result,    32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_op(3'd0, 32'd6, 32'd7, 32'd42, "mul_after_rst");

    // randomized operations against the reference model, mixing idle gaps and back-to-back starts
    for (int k = 0; k < 150; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = rand_operand();
      rb  = rand_operand();
      run_op(rop, ra, rb, model(rop, ra, rb), $sformatf("rand%0d_op%0d", k, rop));
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
